// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall/bubble, dmem wait freeze and timeout flag.
// Optional HAZARD_STATS_EN adds saturating load-use and memory-stall cycle counters.
module hazard_unit #(
    parameter int unsigned AW      = 5,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 id_is_branch,
    input  logic [NSRC*AW-1:0]   ex_src,
    input  logic [NSRC-1:0]      ex_src_used,
    input  logic                 ex_regwrite,
    input  logic                 ex_memtoreg,
    input  logic [AW-1:0]        ex_wreg,
    input  logic                 mem_regwrite,
    input  logic                 mem_memtoreg,
    input  logic [AW-1:0]        mem_wreg,
    input  logic                 wb_regwrite,
    input  logic [AW-1:0]        wb_wreg,
    input  logic                 mem_dreq,
    input  logic                 dmem_ready,
    output logic [2*NSRC-1:0]    id_fwd_sel,
    output logic [2*NSRC-1:0]    ex_fwd_sel,
    output logic                 stall_fe,
    output logic                 bubble_ex,
    output logic                 stall_all,
    output logic [1:0]           state,
    output logic                 dmem_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          lu_stall_cnt,
    output logic [31:0]          mem_stall_cnt
`endif
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        LDUSE = 2'b01,
        MWAIT = 2'b10
    } stateT;

    stateT         stateQ;
    stateT         stateD;
    logic [CW-1:0] waitCnt;
    logic          hzEx;
    logic          hzMem;

    function automatic logic isMatch(input logic [AW-1:0] a, input logic [AW-1:0] d,
                                     input logic we, input logic used);
        return used && we && (a == d) && (d != '0);
    endfunction

    // EX/MEM ALU result has priority over MEM/WB; a load still in EX/MEM has no data yet.
    function automatic logic [1:0] fwdCode(input logic [AW-1:0] a, input logic used,
                                           input logic [AW-1:0] memWreg, input logic memWe,
                                           input logic [AW-1:0] wbWreg, input logic wbWe);
        if (isMatch(a, memWreg, memWe, used)) return 2'b01;
        if (isMatch(a, wbWreg, wbWe, used))   return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin : fwdAndHazard
        id_fwd_sel = '0;
        ex_fwd_sel = '0;
        hzEx       = 1'b0;
        hzMem      = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            id_fwd_sel[2*i +: 2] = fwdCode(id_src[AW*i +: AW], id_src_used[i],
                                           mem_wreg, mem_regwrite & ~mem_memtoreg,
                                           wb_wreg, wb_regwrite);
            ex_fwd_sel[2*i +: 2] = fwdCode(ex_src[AW*i +: AW], ex_src_used[i],
                                           mem_wreg, mem_regwrite & ~mem_memtoreg,
                                           wb_wreg, wb_regwrite);
            if (isMatch(id_src[AW*i +: AW], ex_wreg, ex_regwrite & ex_memtoreg, id_src_used[i]))
                hzEx = 1'b1;
            if (id_is_branch &&
                isMatch(id_src[AW*i +: AW], mem_wreg, mem_regwrite & mem_memtoreg, id_src_used[i]))
                hzMem = 1'b1;
        end
        if (reset) begin
            id_fwd_sel = '0;
            ex_fwd_sel = '0;
            hzEx       = 1'b0;
            hzMem      = 1'b0;
        end
    end

    // Memory freeze dominates the load-use stall.
    always_comb begin : stallLogic
        stall_all = ~reset & mem_dreq & ~dmem_ready;
        stall_fe  = ~reset & (hzEx | hzMem) & ~stall_all;
        bubble_ex = stall_fe;
    end

    always_comb begin : nextState
        stateD = RUN;
        if (stall_all)     stateD = MWAIT;
        else if (stall_fe) stateD = LDUSE;
    end

    always_ff @(posedge clk or posedge reset) begin : stateReg
        if (reset) stateQ <= RUN;
        else       stateQ <= stateD;
    end

    assign state = stateQ;

    // Wait counter saturates at TIMEOUT; the error latches on a stalled edge once saturated.
    always_ff @(posedge clk or posedge reset) begin : waitTimer
        if (reset) begin
            waitCnt  <= '0;
            dmem_err <= 1'b0;
        end else if (stall_all) begin
            if (waitCnt == CW'(TIMEOUT)) dmem_err <= 1'b1;
            else                         waitCnt  <= waitCnt + CW'(1);
        end else begin
            waitCnt <= '0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin : statsCnt
        if (reset) begin
            lu_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (stall_fe && lu_stall_cnt != 32'hFFFF_FFFF)
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            if (stall_all && mem_stall_cnt != 32'hFFFF_FFFF)
                mem_stall_cnt <= mem_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter AW, default 5, register address width.
REQ-002 Parameter NSRC, default 2, source operands checked per stage (ID and EX).
REQ-003 Parameter TIMEOUT, default 255, max consecutive dmem wait cycles before error.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 id_src  input  NSRC*AW  ID-stage source register addresses; source i at [AW*i+AW-1:AW*i].
REQ-007 id_src_used  input  NSRC  per-source valid; unused sources never forward or stall.
REQ-008 id_is_branch  input  1  ID instruction consumes operands in ID (compare/branch).
REQ-009 ex_src  input  NSRC*AW  EX-stage source addresses, same packing.
REQ-010 ex_src_used  input  NSRC  per-source valid for EX.
REQ-011 ex_regwrite, ex_memtoreg  input  1 each  EX-stage instruction writes reg / is load.
REQ-012 ex_wreg  input  AW  EX-stage destination.
REQ-013 mem_regwrite, mem_memtoreg  input  1 each  EX/MEM-register instruction writes reg / is load.
REQ-014 mem_wreg  input  AW  EX/MEM destination.
REQ-015 wb_regwrite  input  1;  wb_wreg  input  AW  MEM/WB write-back port.
REQ-016 mem_dreq  input  1;  dmem_ready  input  1  data-memory request in MEM / completion.
REQ-017 id_fwd_sel, ex_fwd_sel  output  2*NSRC  per-source select at [2i+1:2i]: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
REQ-018 stall_fe  output  1  hold PC and IF/ID;  bubble_ex  output  1  insert NOP into ID/EX.
REQ-019 stall_all  output  1  freeze every pipeline register.
REQ-020 state  output  2  FSM state: 00 RUN, 01 LDUSE, 10 MWAIT.
REQ-021 dmem_err  output  1  sticky memory timeout flag.

Function
REQ-022 Match(a,d,we) SHALL mean a==d and we==1 and d!=0 and source used.
REQ-023 Each fwd_sel source SHALL be 01 on Match with mem_wreg/mem_regwrite and mem_memtoreg==0; else 10 on Match with wb_wreg/wb_regwrite; else 00; EX/MEM wins over MEM/WB.
REQ-024 fwd_sel SHALL be combinational, same-cycle; unaffected by stall_all.
REQ-025 hz_ex SHALL be any used id_src Matching ex_wreg with ex_regwrite and ex_memtoreg both 1.
REQ-026 hz_mem SHALL be id_is_branch and any used id_src Matching mem_wreg with mem_regwrite and mem_memtoreg both 1.
REQ-027 stall_all SHALL equal mem_dreq and not dmem_ready, combinational, in every state.
REQ-028 stall_fe and bubble_ex SHALL equal (hz_ex or hz_mem) and not stall_all; stall_all has priority.
REQ-029 Next state SHALL be MWAIT if stall_all, else LDUSE if stall_fe, else RUN; a branch consuming a load thus takes two LDUSE cycles.
REQ-030 wait_cnt (width ceil(log2(TIMEOUT+1))) SHALL increment each stall_all cycle, saturate at TIMEOUT, clear the cycle stall_all is low.
REQ-031 dmem_err SHALL set on the edge where wait_cnt==TIMEOUT and stall_all==1, and hold until reset.

Reset
REQ-032 Reset SHALL force state=RUN, wait_cnt=0, dmem_err=0 asynchronously.
REQ-033 While reset is high, fwd_sel SHALL be all 00 and stall_fe, bubble_ex, stall_all 0.
REQ-034 Reset mid-MWAIT SHALL abandon the wait; first cycle after release behaves as RUN.

Configuration
REQ-035 Macro HAZARD_STATS_EN defined SHALL add outputs lu_stall_cnt[31:0] (counts stall_fe cycles) and mem_stall_cnt[31:0] (counts stall_all cycles), saturating at 0xFFFFFFFF, reset to 0.
REQ-036 Without HAZARD_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-037 ex_src[0]=3 used, mem_wreg=3, mem_regwrite=1, mem_memtoreg=0, wb_wreg=3, wb_regwrite=1 -> ex_fwd_sel[1:0]=01; mem_wreg=0 -> 10.
REQ-038 id_src[1]=7 used, ex_wreg=7, ex_regwrite=1, ex_memtoreg=1 -> stall_fe=bubble_ex=1 one cycle, state=01 next; same with id_is_branch=1 -> second stall cycle, then RUN.
REQ-039 mem_dreq=1, dmem_ready=0 for 4 cycles with hz_ex true -> stall_all=1, stall_fe=0, state=10, wait_cnt=4; dmem_ready=1 -> state=00 next.
REQ-040 TIMEOUT=3, dmem_ready held 0 for 5 cycles -> dmem_err=1 after 4th edge, stays 1 after ready; clears only on reset.
REQ-041 Assert reset during MWAIT with wait_cnt=2 -> state=00, wait_cnt=0, all selects 00 immediately, no clock edge required.
REQ-042 With HAZARD_STATS_EN, 3 load-use stalls and 5 wait cycles -> lu_stall_cnt=3, mem_stall_cnt=5.
